// File: rtl/mul_seq_ctrl.sv
// Sequential sign/magnitude shift-add multiplier controller.
// One operand pair in flight; the signed 2*width-bit product is presented on a valid/ready port.
module mul_seq_ctrl #(
  parameter int width = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [width-1:0]     a,
  input  logic [width-1:0]     b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*width-1:0]   out,
  output logic                 busy
);

  localparam int CW = $clog2(width);
  localparam int PW = 2 * width;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [width-1:0] r_ma;
  logic [width-1:0] r_mb;
  logic             r_neg;
  logic [CW-1:0]    r_cnt;
  logic [PW-1:0]    r_acc;
  logic [PW-1:0]    r_out;

  logic             w_accept;
  logic             w_last;
  logic [width-1:0] w_abs_a;
  logic [width-1:0] w_abs_b;
  logic [PW-1:0]    w_addend;

  assign w_accept = in_valid && (r_state == S_IDLE);
  assign w_last   = (r_cnt == CW'(width - 1));

  // Negating -2^(width-1) yields 2^(width-1), which is exact as an unsigned width-bit value.
  assign w_abs_a  = a[width-1] ? -a : a;
  assign w_abs_b  = b[width-1] ? -b : b;
  assign w_addend = {{width{1'b0}}, r_ma} << r_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // NOTE: every signal assigned here gets a default first, so no path leaves it unassigned (no latch).
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ma  <= '0;
      r_mb  <= '0;
      r_neg <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_out <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_ma  <= w_abs_a;
            r_mb  <= w_abs_b;
            r_neg <= a[width-1] ^ b[width-1];
            r_acc <= '0;
            r_cnt <= '0;
          end
        end
        S_RUN: begin
          if (r_mb[r_cnt]) r_acc <= r_acc + w_addend;
          r_cnt <= r_cnt + 1'b1;
        end
        S_FIX: begin
          // A zero magnitude negates to zero, so neg=1 with a zero product stays 0.
          r_out <= r_neg ? -r_acc : r_acc;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign out       = r_out;

endmodule

// File: tb/tb_mul_seq_ctrl.sv
// Self-checking bench for mul_seq_ctrl: directed corner cases plus random streaming,
// compared every cycle against a phase/countdown model of the controller.
module tb_mul_seq_ctrl;

  localparam int W  = 6;
  localparam int PW = 2 * W;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [PW-1:0] out;
  logic          busy;

  mul_seq_ctrl #(.width(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out      (out),
    .busy     (busy)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  int n_out  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
    end
  endtask

  function automatic logic [PW-1:0] prod(input logic [W-1:0] x, input logic [W-1:0] y);
    longint p;
    p = longint'($signed(x)) * longint'($signed(y));
    return PW'(p);
  endfunction

  // Reference model: idle / busy for width+1 cycles (RUN+FIX) / done.
  typedef enum {M_IDLE, M_BUSY, M_DONE} mmode_t;
  mmode_t        m_mode = M_IDLE;
  int            m_left = 0;
  logic [PW-1:0] m_pend = '0;
  logic [PW-1:0] m_out  = '0;

  always @(negedge clk) begin
    check("in_ready", in_ready, m_mode == M_IDLE);
    check("busy", busy, m_mode != M_IDLE);
    check("out_valid", out_valid, m_mode == M_DONE);
    check("out", out, m_out);
    if (!rst_n) begin
      m_mode = M_IDLE;
      m_out  = '0;
    end else begin
      case (m_mode)
        M_IDLE: if (in_valid) begin
          m_mode = M_BUSY;
          m_left = W + 1;
          m_pend = prod(a, b);
        end
        M_BUSY: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_DONE;
            m_out  = m_pend;
          end
        end
        M_DONE: if (out_ready) begin
          m_mode = M_IDLE;
          n_out++;
        end
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a pair and return in the cycle after the accepting edge.
  task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    int cyc;
    a = ta;
    b = tb_v;
    in_valid = 1'b1;
    cyc = 0;
    while (!in_ready && cyc < 64) begin
      step();
      cyc++;
    end
    check("send_ready", in_ready, 1'b1);
    step();
    in_valid = 1'b0;
  endtask

  // Called in cycle k+1; waits for out_valid, checks latency/value, holds, then handshakes.
  task automatic collect(input string nm, input logic [PW-1:0] exp, input int hold);
    int cyc;
    cyc = 1;
    while (!out_valid && cyc < 64) begin
      step();
      cyc++;
    end
    check({nm, "_latency"}, cyc, W + 2);
    check({nm, "_value"}, out, exp);
    repeat (hold) step();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check({nm, "_idle_after"}, in_ready, 1'b1);
  endtask

  function automatic logic [W-1:0] pick();
    if ($urandom_range(7) == 0) return W'(32);
    return W'($urandom);
  endfunction

  initial begin
    int n_sent;
    int guard;
    int out0;
    logic will;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_out", out, '0);

    check("model_pos", prod(6'd3, 6'd5), 12'h00F);
    check("model_neg", prod(6'h3D, 6'd5), 12'hFF1);
    check("model_minsq", prod(6'h20, 6'h20), 12'h400);

    step();
    send(6'd3, 6'd5);
    check("basic_busy_c1", busy, 1'b1);
    collect("basic", 12'h00F, 0);
    send(6'h3D, 6'd5);   collect("neg_pos", 12'hFF1, 0);
    send(6'h3D, 6'h3B);  collect("neg_neg", 12'h00F, 1);
    send(6'd0, 6'h39);   collect("zero_neg", 12'h000, 0);
    send(6'h20, 6'h20);  collect("min_min", 12'h400, 0);
    send(6'h20, 6'd31);  collect("min_max", 12'hC20, 2);
    send(6'h20, 6'd1);   collect("min_one", 12'hFE0, 0);

    // Backpressure with a new pair waiting in DONE.
    send(6'd7, 6'h3E);
    begin
      int cyc;
      cyc = 1;
      while (!out_valid && cyc < 64) begin step(); cyc++; end
    end
    a = 6'h20; b = 6'd31; in_valid = 1'b1;
    repeat (5) begin
      step();
      check("bp_hold_valid", out_valid, 1'b1);
      check("bp_hold_out", out, 12'hFF2);
      check("bp_hold_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_release_idle", in_ready, 1'b1);
    check("bp_release_valid", out_valid, 1'b0);
    step();
    in_valid = 1'b0;
    check("bp_pending_taken", busy, 1'b1);
    collect("bp_pending", 12'hC20, 0);

    // Reset during RUN with cnt=3, while handshake inputs are active.
    send(6'h15, 6'h0B);
    repeat (3) step();
    rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b1; a = 6'd1; b = 6'd1;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    check("rstrun_in_ready", in_ready, 1'b1);
    check("rstrun_out_valid", out_valid, 1'b0);
    check("rstrun_out", out, '0);
    check("rstrun_busy", busy, 1'b0);
    repeat (20) step();
    check("rstrun_no_emit", out_valid, 1'b0);

    // Reset in IDLE with in_valid high: no handshake recorded.
    rst_n = 1'b0; in_valid = 1'b1;
    step();
    rst_n = 1'b1; in_valid = 1'b0;
    step();
    check("rstidle_busy", busy, 1'b0);
    out_ready = 1'b0;

    // Random streaming.
    out0 = n_out;
    n_sent = 0;
    guard = 0;
    while (n_sent < 1000 && guard < 60000) begin
      will = in_valid && in_ready;
      step();
      guard++;
      if (will) begin
        n_sent++;
        in_valid = 1'b0;
      end
      if (!in_valid && n_sent < 1000 && $urandom_range(3) != 0) begin
        a = pick();
        b = pick();
        in_valid = 1'b1;
      end
      out_ready = ($urandom_range(2) != 0);
    end
    check("stream_sent", n_sent, 1000);
    out_ready = 1'b1;
    guard = 0;
    while (busy && guard < 64) begin step(); guard++; end
    out_ready = 1'b0;
    step();
    check("stream_drained", busy, 1'b0);
    check("stream_count", n_out - out0, n_sent);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mul_seq_ctrl.md
# mul_seq_ctrl

Sequential controller for a shared two's-complement multiplier datapath. It accepts one operand pair at a time over a valid/ready handshake and sequences a sign/magnitude shift-add over `width` iterations. It then applies the result sign and presents the `2*width`-bit signed product on a valid/ready output. It sits between operand producers and downstream consumers wherever multiplier area matters more than throughput.

## Interface

- `width`, default 6: operand width in bits, two's complement; must be at least 2.
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `in_valid`  in  1  operand pair on `a`/`b` is valid.
- `in_ready`  out  1  controller can accept an operand pair.
- `a`  in  `width`  multiplicand, two's complement.
- `b`  in  `width`  multiplier, two's complement.
- `out_valid`  out  1  `out` holds a completed product.
- `out_ready`  in  1  consumer accepts `out`.
- `out`  out  `2*width`  signed product `a*b`, two's complement.
- `busy`  out  1  high in every state except IDLE.

## Operation

- **States:**
  - IDLE: `in_ready`=1.
  - RUN: iterating.
  - FIX: sign application.
  - DONE: `out_valid`=1.
- **IDLE → RUN** on `in_valid & in_ready`. Capture on that edge:
  - `ma` = |a| as a `width`-bit unsigned value (negate when `a[width-1]`=1).
  - `mb` = |b| likewise.
  - `neg` = `a[width-1] ^ b[width-1]`.
  - `acc` = 0 (`2*width` bits), `cnt` = 0.
- **Magnitude rule:** |-2^(width-1)| = 2^(width-1) must be represented exactly in `width` unsigned bits. The most-negative operand is never collapsed to zero.
- **RUN, one iteration per cycle:**
  - If `mb[cnt]`=1, then `acc` ← `acc + (ma << cnt)`, zero-extended to `2*width` bits.
  - `cnt` ← `cnt`+1.
  - After the iteration with `cnt` = `width-1`, go to FIX.
  - Exactly `width` RUN cycles every time; no early exit on a zero operand.
- **FIX:**
  - `out` ← `neg ? (~acc + 1) : acc`, truncated to `2*width` bits; → DONE.
  - Product of zero with `neg`=1 must yield 0.
  - All products, including (-2^(width-1))², are exact in `2*width` bits; no overflow is possible.
- **DONE:**
  - `out_valid`=1 and `out` is held stable until `out_valid & out_ready`, then → IDLE.
  - `out` keeps its value after the handshake until the next FIX.
- `in_valid` while `in_ready`=0 is ignored. The producer must hold `a`/`b` until the handshake completes.
- **Reset** (`rst_n`=0 at any edge, in any state): state → IDLE, any in-flight operation is discarded, `acc`=0, `cnt`=0, `out`=0.

## Timing

- **Reset values:**
  - `in_ready`=1 (IDLE).
  - `out_valid`=0.
  - `busy`=0.
  - `out`=0.
- **Outputs:** all are Moore-decoded from registered state. No combinational path from `in_valid` or `out_ready` to any output.
- **Latency:** input handshake at edge k.
  - RUN spans cycles k+1 … k+`width`.
  - FIX runs in cycle k+`width`+1.
  - `out_valid` is high from cycle k+`width`+2.
- **Throughput:** one product per `width`+3 cycles with `out_ready` tied high. `in_ready` returns high the cycle after the output handshake.
- **Back-to-back:**
  - No operand is accepted in DONE; `in_ready`=0 there even while `out_ready`=1.
  - No output skid; `out_valid` drops the cycle after the handshake.
- **Reset asserted in the same cycle as `in_valid` or `out_ready`:** reset wins; no handshake is recorded.

## Test plan

- **Basic multiply:** `width`=6, a=3, b=5 → `out`=12'h00F. `out_valid` first high exactly 8 cycles after the accepting edge; `busy` high for cycles 1-8.
- **Sign combinations:**
  - a=-3 (6'h3D), b=5 → 12'hFF1.
  - a=-3, b=-5 → 12'h00F.
  - a=0, b=-7 → 12'h000.
- **Most-negative operand:**
  - a=b=6'h20 (-32) → 12'h400 (1024).
  - a=6'h20, b=31 → 12'hC20 (-992).
  - a=6'h20, b=1 → 12'hFE0.
- **Backpressure:** `out_ready` held low 5 cycles in DONE → `out` and `out_valid` stable; `in_ready`=0; a new `in_valid` is ignored. Raise `out_ready` → IDLE next cycle, then the pending pair is accepted.
- **Reset mid-operation:** assert `rst_n`=0 for one cycle during RUN (cnt=3) → next cycle IDLE, `out_valid`=0, `out`=0, `busy`=0. No product is ever emitted for the discarded pair.
- **Random streaming:** 1000 random operand pairs with random `in_valid`/`out_ready` gaps → every `out` equals the signed product `a*b` (`2*width` bits), in order, with no loss or duplication.
